// File: rtl/t05_display_pkg.sv
// Shared constants and the hex-to-segment encoder for the team_05 display driver.
// Segment bytes are active-high {g,f,e,d,c,b,a}, with bit 0 = segment a.
package t05_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG7_LUT [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] hex);
    return SEG7_LUT[hex];
  endfunction

endpackage

// File: rtl/t05_hex7seg.sv
// Combinational hex digit to seven-segment decoder.
// Used for the scanned digit and for every byte of the parallel image.
module t05_hex7seg
  import t05_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = seg7_encode(hex);

endmodule

// File: rtl/t05_display_scan.sv
// Time-multiplexed seven-segment driver with a frame-synchronous double buffer,
// per-digit enable/blink, leading-zero blanking and a parallel segment image.
module t05_display_scan
  import t05_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1024,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] seq,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [8*NUM_DIGITS-1:0] ssds,
  output logic                    frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRESC_W-1:0] LAST_PRESC = PRESC_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0]   LAST_FRM   = FRM_W'(BLINK_FRAMES - 1);

  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [FRM_W-1:0]        frm_cnt_q, frm_cnt_d;
  logic                    phase_q, phase_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic [8*NUM_DIGITS-1:0] ssds_q, ssds_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    boundary;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   visible;
  logic [3:0]              scan_hex;
  logic                    scan_vis;
  logic [6:0]              scan_seg;
  logic [7*NUM_DIGITS-1:0] digit_seg;

  assign tick     = (presc_q == LAST_PRESC);
  assign boundary = tick && (idx_q == LAST_IDX);

  // Walk from the most significant digit down so the zero run includes digit i.
  always_comb begin
    all_zero = 1'b1;
    visible  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero & (active_q[4*i +: 4] == 4'h0);
      visible[i] = digit_en[i] & ~(blink_en[i] & phase_q)
                 & ~(blank_lz & (i != 0) & all_zero);
    end
  end

  always_comb begin
    scan_hex = 4'h0;
    scan_vis = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        scan_hex = active_q[4*i +: 4];
        scan_vis = visible[i];
      end
    end
  end

  t05_hex7seg u_scan_hex (
    .hex (scan_hex),
    .seg (scan_seg)
  );

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_par_hex
    t05_hex7seg u_hex (
      .hex (active_q[4*g +: 4]),
      .seg (digit_seg[7*g +: 7])
    );
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    // Active only changes at a frame boundary; a load landing on the boundary goes straight in.
    active_d     = active_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    if (boundary) begin
      if (load) begin
        active_d = seq;
      end else if (pend_valid_q) begin
        active_d = pending_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pending_d    = seq;
      pend_valid_d = 1'b1;
    end

    frm_cnt_d = frm_cnt_q;
    phase_d   = phase_q;
    if (boundary) begin
      if (frm_cnt_q == LAST_FRM) begin
        frm_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        frm_cnt_d = frm_cnt_q + 1'b1;
      end
    end

    seg_d     = scan_vis ? scan_seg : SEG_BLANK;
    dig_sel_d = NUM_DIGITS'(1) << idx_q;
    ssds_d    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ssds_d[8*i +: 8] = {1'b0, visible[i] ? digit_seg[7*i +: 7] : SEG_BLANK};
    end
    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      idx_q        <= '0;
      presc_q      <= '0;
      frm_cnt_q    <= '0;
      phase_q      <= 1'b0;
      seg_q        <= '0;
      dig_sel_q    <= '0;
      ssds_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      frm_cnt_q    <= frm_cnt_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      ssds_q       <= ssds_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign ssds       = ssds_q;
  assign frame_done = frame_done_q;

endmodule
